// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: reset vector, memory map region bases and
// the prefetch entry layout carried from the instruction port to decode.
package riscv_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // Upper halves of the region base addresses.
  localparam logic [15:0] ROM_BASE_HI  = 16'h0000;
  localparam logic [15:0] MMIO_BASE_HI = 16'h7000;
  localparam logic [15:0] RAM_BASE_HI  = 16'h8000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries between the instruction port and
// decode; flush has priority over push and pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;
  logic             write_en_s;

  always_comb begin
    do_push_s  = push && (count_q != FULL_CNT);
    do_pop_s   = pop && (count_q != {CNT_W{1'b0}});
    write_en_s = do_push_s && !flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (write_en_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word fetches to a one-cycle-latency ROM port,
// buffers returns in fetch_fifo and serves decode. Optional FETCH_ALIGN_CHECK_EN.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  output logic        imem_enable,
  input  logic [31:0] imem_data,
  input  logic        imem_wait,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_misaligned
);

  localparam int               CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             pending_q, pending_d;
  logic             halted_q, halted_d;
  logic             misaligned_q, misaligned_d;
  logic [31:0]      target_pc_s;
  logic             bad_target_s;
  logic             issue_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] count_s;
  fetch_entry_t     push_entry_s;
  fetch_entry_t     head_s;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_pc_s  = redirect_pc;
  assign bad_target_s = is_misaligned(redirect_pc);
`else
  assign target_pc_s  = word_align(redirect_pc);
  assign bad_target_s = 1'b0;
`endif

  // A request is only issued if its response is guaranteed a FIFO slot,
  // counting the response already in flight.
  always_comb begin
    issue_s  = !reset && !halted_q && !redirect_valid &&
               ((count_s + CNT_W'(pending_q)) < FULL_CNT);
    accept_s = issue_s && !imem_wait;
  end

  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    pending_d    = 1'b0;
    halted_d     = halted_q;
    misaligned_d = misaligned_q;
    if (redirect_valid) begin
      pc_d         = target_pc_s;
      pending_d    = 1'b0;
      halted_d     = bad_target_s;
      misaligned_d = bad_target_s;
    end else if (accept_s) begin
      pc_d      = pc_q + 32'd4;
      pending_d = 1'b1;
      req_pc_d  = pc_q;
    end else begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'h0000_0000;
      pending_q    <= 1'b0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      pending_q    <= pending_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

  // The response of a request cancelled by a redirect is dropped here.
  always_comb begin
    push_s             = pending_q && !redirect_valid;
    pop_s              = out_valid && out_ready;
    push_entry_s.pc    = req_pc_q;
    push_entry_s.instr = imem_data;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .head      (head_s),
    .count     (count_s)
  );

  assign imem_enable      = issue_s;
  assign imem_address     = pc_q;
  assign out_valid        = (count_s != {CNT_W{1'b0}});
  assign out_pc           = out_valid ? head_s.pc : 32'h0000_0000;
  assign out_instr        = out_valid ? head_s.instr : 32'h0000_0000;
  assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: ROM model plus an in-order PC scoreboard.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic        imem_enable;
  logic [31:0] imem_data = 32'h0;
  logic        imem_wait;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_misaligned;

  int          n_cmp = 0;
  int          n_err = 0;
  int          hs_cnt = 0;
  int          h0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_enable      (imem_enable),
    .imem_data        (imem_data),
    .imem_wait        (imem_wait),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h0000_0013 + (a << 5);
  endfunction

  always @(posedge clk) begin
    if (imem_enable && !imem_wait) imem_data <= rom_word(imem_address);
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic sb_reset(input logic [31:0] base);
    exp_q.delete();
    exp_next = base;
    repeat (8) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc, input logic [31:0] base);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    out_ready      = 1'b0;
    sb_reset(base);
    @(negedge clk);
    chk_eq("redir_noissue", 32'(imem_enable), 32'd0);
    tick();
    redirect_valid = 1'b0;
  endtask

  // Scoreboard: every decode handshake pops the next expected PC.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      hs_cnt++;
      chk_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk_eq("out_pc", out_pc, exp_q[0]);
        chk_eq("out_instr", out_instr, rom_word(exp_q[0]));
        void'(exp_q.pop_front());
        exp_q.push_back(exp_next);
        exp_next = exp_next + 32'd4;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imem_wait = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b0;
    repeat (2) tick();
    chk_eq("rst_en", 32'(imem_enable), 32'd0);
    chk_eq("rst_addr", imem_address, 32'h0);
    chk_eq("rst_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_instr", out_instr, 32'h0);
    chk_eq("rst_pc", out_pc, 32'h0);
    chk_eq("rst_misal", 32'(fetch_misaligned), 32'd0);

    // Reset release and streaming
    reset = 1'b0; sb_reset(32'h0); out_ready = 1'b1;
    @(negedge clk);
    chk_eq("first_en", 32'(imem_enable), 32'd1);
    chk_eq("first_addr", imem_address, 32'h0);
    tick();
    @(negedge clk); chk_eq("lat_early", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk); chk_eq("lat_first", 32'(out_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk); chk_eq("steady", 32'(out_valid), 32'd1);
    end
    tick();

    // Decode stall fills exactly DEPTH entries
    out_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk_eq("full_en", 32'(imem_enable), 32'd0);
    chk_eq("full_valid", 32'(out_valid), 32'd1);
    tick();
    h0 = hs_cnt; imem_wait = 1'b1; out_ready = 1'b1;
    repeat (6) begin @(negedge clk); tick(); end
    chk_eq("depth_buffered", 32'(hs_cnt - h0), 32'd4);
    imem_wait = 1'b0;
    repeat (6) tick();

    // Redirect with 3 buffered and 1 in flight
    do_redirect(32'h40, 32'h40);
    repeat (4) tick();
    do_redirect(32'h100, 32'h100);
    out_ready = 1'b1;
    @(negedge clk);
    chk_eq("redir_en", 32'(imem_enable), 32'd1);
    chk_eq("redir_addr", imem_address, 32'h100);
    chk_eq("redir_flush", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk); chk_eq("redir_t2", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk); chk_eq("redir_lat", 32'(out_valid), 32'd1);
    repeat (5) tick();

    // imem_wait holds the request for 0x8
    do_redirect(32'h0, 32'h0);
    out_ready = 1'b1;
    repeat (2) tick();
    imem_wait = 1'b1;
    @(negedge clk);
    chk_eq("wait_hold0", imem_address, 32'h8);
    chk_eq("wait_en0", 32'(imem_enable), 32'd1);
    tick();
    @(negedge clk);
    chk_eq("wait_hold1", imem_address, 32'h8);
    chk_eq("wait_en1", 32'(imem_enable), 32'd1);
    tick();
    imem_wait = 1'b0;
    @(negedge clk); chk_eq("wait_release", imem_address, 32'h8);
    repeat (7) tick();

    // Address wrap
    do_redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    out_ready = 1'b1; h0 = hs_cnt;
    repeat (6) tick();
    chk_eq("wrap_count", 32'(hs_cnt - h0), 32'd4);

`ifdef FETCH_ALIGN_CHECK_EN
    do_redirect(32'h102, 32'h0);
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("misal_flag", 32'(fetch_misaligned), 32'd1);
      chk_eq("misal_en", 32'(imem_enable), 32'd0);
      chk_eq("misal_valid", 32'(out_valid), 32'd0);
      tick();
    end
    do_redirect(32'h200, 32'h200);
    out_ready = 1'b1; h0 = hs_cnt;
    @(negedge clk);
    chk_eq("realign_flag", 32'(fetch_misaligned), 32'd0);
    chk_eq("realign_addr", imem_address, 32'h200);
    repeat (5) tick();
    chk_eq("realign_count", 32'(hs_cnt - h0), 32'd3);
`else
    do_redirect(32'h102, 32'h100);
    out_ready = 1'b1; h0 = hs_cnt;
    @(negedge clk);
    chk_eq("force_flag", 32'(fetch_misaligned), 32'd0);
    chk_eq("force_align", imem_address, 32'h100);
    repeat (5) tick();
    chk_eq("force_count", 32'(hs_cnt - h0), 32'd3);
`endif

    // Reset mid-operation
    repeat (2) tick();
    reset = 1'b1;
    #1;
    chk_eq("mrst_valid", 32'(out_valid), 32'd0);
    chk_eq("mrst_en", 32'(imem_enable), 32'd0);
    chk_eq("mrst_addr", imem_address, 32'h0);
    chk_eq("mrst_pc", out_pc, 32'h0);
    repeat (2) tick();
    reset = 1'b0; sb_reset(32'h0); h0 = hs_cnt;
    @(negedge clk);
    chk_eq("mrst_first_en", 32'(imem_enable), 32'd1);
    chk_eq("mrst_first_addr", imem_address, 32'h0);
    repeat (6) tick();
    chk_eq("mrst_count", 32'(hs_cnt - h0), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
